fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage of the 16-bit RISC core, directly upstream of the instruction decoder. It issues word addresses to instruction memory over a req/ack handshake and registers the returned 16-bit instruction. It presents the instruction with a valid flag that drives the decoder enable, and holds it under stall via a one-entry skid buffer. Branch redirects from execute flush in-flight and buffered instructions.

Parameters:
RESET_PC, 16'h0000, fetch address loaded on reset
PC_INC, 16'd1, address increment per instruction (word-addressed memory)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous, active-high reset
i_stall  input  1  decoder/back-end cannot accept; o_inst consumed on a cycle with o_inst_valid=1 and i_stall=0
i_branch_en  input  1  redirect request, single-cycle pulse
i_branch_addr  input  16  redirect target
o_imem_req  output  1  fetch request, registered
o_imem_addr  output  16  fetch address, registered, stable while o_imem_req=1
i_imem_ack  input  1  memory response; data valid in the same cycle; only meaningful while o_imem_req=1
i_imem_data  input  16  instruction word
o_inst  output  16  instruction to decoder
o_inst_valid  output  1  o_inst valid, drives decoder enable
o_pc  output  16  address o_inst was fetched from

Behaviour:
- Reset is asynchronous, active-high. On reset: o_imem_req=0, o_imem_addr=RESET_PC, o_inst=0, o_inst_valid=0, o_pc=0, skid empty, state S_RST. Assertion mid-operation drops o_imem_req immediately and discards all buffered data.
- States: S_RST, S_FETCH, S_FULL, S_DRAIN.
- S_RST: on the first edge after reset release, go to S_FETCH with o_imem_req<=1.
- Bus rule: once o_imem_req=1, o_imem_req and o_imem_addr stay unchanged until an edge with i_imem_ack=1. One request outstanding at most.
- S_FETCH, ack, output empty or consumed this cycle: o_inst<=data, o_pc<=o_imem_addr, o_inst_valid<=1, o_imem_addr<=o_imem_addr+PC_INC. Req stays 1, giving back-to-back throughput of 1 instruction/cycle with zero-wait memory.
- S_FETCH, ack, output valid and i_stall=1: data and address go to the skid, o_imem_addr increments, o_imem_req<=0, go to S_FULL.
- S_FETCH, no ack: if the output is consumed, o_inst_valid<=0.
- S_FULL: no request. When the output is consumed, skid moves to o_inst/o_pc, o_inst_valid stays 1, skid empties, o_imem_req<=1, go to S_FETCH.
- Stall holds o_inst, o_pc and o_inst_valid unchanged.
- Branch (i_branch_en=1) has top priority over stall and ack, in any state except S_RST:
  - o_inst_valid<=0 and skid emptied.
  - If o_imem_req=1 and i_imem_ack=0: store i_branch_addr in the target register, go to S_DRAIN. Req and address are held.
  - Otherwise (no request, or ack this cycle): returned data is discarded, o_imem_addr<=i_branch_addr, o_imem_req<=1, go to S_FETCH.
- S_DRAIN: o_inst_valid=0. On ack, data is discarded, o_imem_addr<=target, go to S_FETCH with req held at 1. A further branch in S_DRAIN overwrites the target; if it coincides with the ack, the new branch address wins.
- Address arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000 with no flag.
- o_inst keeps its last value when o_inst_valid=0; the decoder must qualify with valid.

Test Plan:
- Reset/startup: hold i_rst 3 cycles, release, memory acks every req with data=addr^16'h1700 -> req rises 1 cycle after release, addr 0,1,2,…; o_inst=16'h1700,16'h1701,… with o_pc=0,1,2; valid continuous from 2nd edge.
- Stall/skid: stream running, i_stall=1 for 4 cycles while ack arrives -> o_inst frozen, skid captures next word, req low in S_FULL; on stall release, words delivered in order with no loss or duplication.
- Branch with outstanding req: memory delays ack 3 cycles, pulse i_branch_en with addr 16'h0040 -> valid drops next edge, old ack data discarded, next req addr 16'h0040, first delivered o_pc=16'h0040.
- Branch coincident with ack and stall: full output, skid empty, ack + stall + branch to 16'h0100 in one cycle -> ack data dropped, skid empty, req addr 16'h0100 next cycle.
- Wrap: RESET_PC=16'hFFFE, zero-wait memory -> o_pc sequence FFFE, FFFF, 0000, 0001.
- Async reset mid-burst: assert i_rst between edges during a stall with the skid full -> o_imem_req and o_inst_valid fall without a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with req/ack memory bus, one-entry skid buffer and branch redirect
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_stall               back-end cannot accept o_inst this cycle
//   i_branch_en/addr      redirect pulse and target
//   o_imem_req/addr       registered fetch request, held until acked
//   i_imem_ack/data       same-cycle memory response
//   o_inst/valid/pc       instruction to decoder, its valid flag and fetch address
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC = 16'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_en,
  input  logic [15:0] i_branch_addr,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_inst,
  output logic        o_inst_valid,
  output logic [15:0] o_pc
);
  localparam logic [1:0] S_RST = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  logic [1:0] state_q, state_d;
  logic req_q, req_d, valid_q, valid_d;
  logic [15:0] addr_q, addr_d, inst_q, inst_d, pc_q, pc_d;
  logic [15:0] skid_inst_q, skid_inst_d, skid_pc_q, skid_pc_d, tgt_q, tgt_d;
  logic ack, take;
  assign ack = req_q & i_imem_ack;
  // output register can load new data: empty, or being consumed this cycle
  assign take = ~valid_q | ~i_stall;
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    inst_d = inst_q;
    pc_d = pc_q;
    valid_d = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d = skid_pc_q;
    tgt_d = tgt_q;
    if (state_q == S_RST) begin
      state_d = S_FETCH;
      req_d = 1'b1;
    end else if (i_branch_en) begin
      valid_d = 1'b0;
      // an unacked request must complete before the bus can be redirected
      if (req_q && !i_imem_ack) begin
        tgt_d = i_branch_addr;
        state_d = S_DRAIN;
      end else begin
        addr_d = i_branch_addr;
        req_d = 1'b1;
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ack && take) begin
            inst_d = i_imem_data;
            pc_d = addr_q;
            valid_d = 1'b1;
            addr_d = addr_q + PC_INC;
          end else if (ack) begin
            skid_inst_d = i_imem_data;
            skid_pc_d = addr_q;
            addr_d = addr_q + PC_INC;
            req_d = 1'b0;
            state_d = S_FULL;
          end else if (take) begin
            valid_d = 1'b0;
          end
        end
        S_FULL: begin
          if (!i_stall) begin
            inst_d = skid_inst_q;
            pc_d = skid_pc_q;
            req_d = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          valid_d = 1'b0;
          if (ack) begin
            addr_d = tgt_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_RST;
      endcase
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_RST;
      req_q <= 1'b0;
      addr_q <= RESET_PC;
      inst_q <= 16'h0000;
      pc_q <= 16'h0000;
      valid_q <= 1'b0;
      skid_inst_q <= 16'h0000;
      skid_pc_q <= 16'h0000;
      tgt_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      addr_q <= addr_d;
      inst_q <= inst_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q <= skid_pc_d;
      tgt_q <= tgt_d;
    end
  end
  assign o_imem_req = req_q;
  assign o_imem_addr = addr_q;
  assign o_inst = inst_q;
  assign o_inst_valid = valid_q;
  assign o_pc = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks plus an in-order delivery scoreboard for fetch_unit
module tb_fetch_unit;
  logic clk, rst, stall, branch;
  logic [15:0] branch_addr;
  logic req, ack, valid;
  logic [15:0] addr, data, inst, pc;
  logic req2, ack2, valid2;
  logic [15:0] addr2, data2, inst2, pc2;
  logic stall2, branch2;
  logic [15:0] branch_addr2;
  int mem_delay;
  int errors, checks;

  fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd1)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_en(branch),
    .i_branch_addr(branch_addr), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_data(data), .o_inst(inst),
    .o_inst_valid(valid), .o_pc(pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .PC_INC(16'd1)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_stall(stall2), .i_branch_en(branch2),
    .i_branch_addr(branch_addr2), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_data(data2), .o_inst(inst2),
    .o_inst_valid(valid2), .o_pc(pc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: data = addr ^ 16'h1700, ack after mem_delay unacked cycles of a request
  initial begin
    int cnt;
    bit acked;
    cnt = 0;
    acked = 0;
    ack = 0;
    data = 0;
    ack2 = 0;
    data2 = 0;
    forever begin
      @(negedge clk);
      #1;
      if (acked) cnt = 0;
      if (req && cnt >= mem_delay) ack = 1'b1;
      else begin
        ack = 1'b0;
        if (req) cnt++;
      end
      acked = ack;
      data = addr ^ 16'h1700;
      ack2 = req2;
      data2 = addr2 ^ 16'h1700;
    end
  end

  // scoreboard: every consumed instruction must be the next address of the program
  // stream (restarted by reset or a branch), hold under stall, and obey the bus rule
  initial begin
    logic [15:0] exp_pc, p_pc, p_inst, p_addr;
    logic p_valid, p_req;
    exp_pc = 16'h0000;
    p_pc = 0;
    p_inst = 0;
    p_addr = 0;
    p_valid = 0;
    p_req = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) exp_pc = 16'h0000;
      else begin
        if (p_valid && !stall) begin
          chk("sb_pc", p_pc, exp_pc);
          chk("sb_inst", p_inst, exp_pc ^ 16'h1700);
          exp_pc = exp_pc + 16'd1;
        end
        if (branch) begin
          exp_pc = branch_addr;
          chk("sb_branch_valid", {15'd0, valid}, 16'd0);
          if (!p_req || ack) begin
            chk("sb_branch_req", {15'd0, req}, 16'd1);
            chk("sb_branch_addr", addr, branch_addr);
          end
        end else if (p_valid && stall) begin
          chk("sb_hold_pc", pc, p_pc);
          chk("sb_hold_inst", inst, p_inst);
          chk("sb_hold_valid", {15'd0, valid}, 16'd1);
        end
        if (p_req && !ack) begin
          chk("sb_bus_req", {15'd0, req}, 16'd1);
          chk("sb_bus_addr", addr, p_addr);
        end
      end
      p_pc = pc;
      p_inst = inst;
      p_addr = addr;
      p_valid = valid;
      p_req = req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int i;
    i = 0;
    while (!valid && i < budget) begin
      cyc(1);
      i++;
    end
    chk("wait_valid", {15'd0, valid}, 16'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    stall = 1'b0;
    branch = 1'b0;
    branch_addr = 16'h0000;
    stall2 = 1'b0;
    branch2 = 1'b0;
    branch_addr2 = 16'h0000;
    mem_delay = 0;
    cyc(3);
    chk("rst_req", {15'd0, req}, 16'd0);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_wrap_addr", addr2, 16'hFFFE);
    chk("rst_wrap_pc", pc2, 16'h0000);
    rst = 1'b0;
    cyc(1);
    chk("start_req", {15'd0, req}, 16'd1);
    chk("start_addr", addr, 16'h0000);
    chk("start_valid", {15'd0, valid}, 16'd0);
    chk("wrap_start_addr", addr2, 16'hFFFE);
    cyc(1);
    chk("first_valid", {15'd0, valid}, 16'd1);
    chk("first_inst", inst, 16'h1700);
    chk("first_pc", pc, 16'h0000);
    chk("wrap_pc0", pc2, 16'hFFFE);
    chk("wrap_inst0", inst2, 16'hE8FE);
    cyc(1);
    chk("second_inst", inst, 16'h1701);
    chk("second_pc", pc, 16'h0001);
    chk("wrap_pc1", pc2, 16'hFFFF);
    cyc(1);
    chk("third_pc", pc, 16'h0002);
    chk("third_addr", addr, 16'h0003);
    chk("wrap_pc2", pc2, 16'h0000);
    stall = 1'b1;
    cyc(1);
    chk("full_req", {15'd0, req}, 16'd0);
    chk("full_pc", pc, 16'h0002);
    chk("full_addr", addr, 16'h0004);
    chk("wrap_pc3", pc2, 16'h0001);
    chk("wrap_inst3", inst2, 16'h1701);
    cyc(3);
    chk("stall_req", {15'd0, req}, 16'd0);
    chk("stall_pc", pc, 16'h0002);
    chk("stall_valid", {15'd0, valid}, 16'd1);
    stall = 1'b0;
    cyc(1);
    chk("skid_pc", pc, 16'h0003);
    chk("skid_inst", inst, 16'h1703);
    chk("skid_req", {15'd0, req}, 16'd1);
    chk("skid_addr", addr, 16'h0004);
    cyc(1);
    chk("after_skid_pc", pc, 16'h0004);
    mem_delay = 3;
    stall = 1'b1;
    cyc(2);
    chk("pre_branch_valid", {15'd0, valid}, 16'd1);
    branch = 1'b1;
    branch_addr = 16'h0040;
    cyc(1);
    branch = 1'b0;
    stall = 1'b0;
    chk("drain_valid", {15'd0, valid}, 16'd0);
    chk("drain_req", {15'd0, req}, 16'd1);
    chk("drain_addr", addr, 16'h0005);
    cyc(1);
    chk("redirect_addr", addr, 16'h0040);
    chk("redirect_valid", {15'd0, valid}, 16'd0);
    wait_valid(20);
    chk("target_pc", pc, 16'h0040);
    chk("target_inst", inst, 16'h1740);
    mem_delay = 0;
    cyc(2);
    chk("pre_coinc_valid", {15'd0, valid}, 16'd1);
    stall = 1'b1;
    branch = 1'b1;
    branch_addr = 16'h0100;
    cyc(1);
    branch = 1'b0;
    stall = 1'b0;
    chk("coinc_valid", {15'd0, valid}, 16'd0);
    chk("coinc_addr", addr, 16'h0100);
    chk("coinc_req", {15'd0, req}, 16'd1);
    cyc(1);
    chk("coinc_pc", pc, 16'h0100);
    chk("coinc_inst", inst, 16'h1600);
    cyc(1);
    chk("coinc_next_pc", pc, 16'h0101);
    stall = 1'b1;
    cyc(1);
    chk("rst_full_req", {15'd0, req}, 16'd0);
    chk("rst_full_valid", {15'd0, valid}, 16'd1);
    cyc(1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req", {15'd0, req}, 16'd0);
    chk("async_valid", {15'd0, valid}, 16'd0);
    chk("async_addr", addr, 16'h0000);
    cyc(1);
    rst = 1'b0;
    stall = 1'b0;
    cyc(1);
    chk("restart_req", {15'd0, req}, 16'd1);
    chk("restart_addr", addr, 16'h0000);
    chk("restart_valid", {15'd0, valid}, 16'd0);
    cyc(1);
    chk("restart_pc", pc, 16'h0000);
    chk("restart_inst", inst, 16'h1700);
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
